uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of received bytes and the register-file write data.
REQ-002 Parameter ADDR_WIDTH, default 4, register-file address width; the address is taken from the low bits of the address byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, inter-byte idle limit in CLK cycles; used only when FRAME_TIMEOUT_EN is defined.
REQ-004 CLK  in  1  the single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 RX_P_DATA  in  DATA_WIDTH  byte from the UART receiver; valid only while RX_D_VLD=1.
REQ-007 RX_D_VLD  in  1  one-cycle strobe; one received byte per strobe.
REQ-008 Parity_Error  in  1  qualifies the byte on the same cycle as RX_D_VLD; 1 means the byte is corrupt.
REQ-009 Frame_Error  in  1  qualifies the byte on the same cycle as RX_D_VLD; 1 means the byte is corrupt.
REQ-010 WrEn  out  1  one-cycle register-file write strobe.
REQ-011 RdEn  out  1  one-cycle register-file read strobe.
REQ-012 Address  out  ADDR_WIDTH  register-file address; valid while WrEn or RdEn is 1.
REQ-013 WrData  out  DATA_WIDTH  register-file write data; valid while WrEn is 1.
REQ-014 ALU_EN  out  1  one-cycle ALU start strobe.
REQ-015 ALU_FUN  out  4  ALU function; valid while ALU_EN is 1.
REQ-016 CMD_BUSY  out  1  high whenever the state is not IDLE.
REQ-017 CMD_ERR  out  1  one-cycle strobe when a command is rejected or aborted.

Function
REQ-018 The block SHALL implement these FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN_S.
REQ-019 In IDLE, a valid byte SHALL select the next state by opcode:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> ALU_OPA
  - 0xDD -> ALU_FUN_S
REQ-020 In IDLE, any other valid byte SHALL stay in IDLE and pulse CMD_ERR.
REQ-021 A valid byte in WR_ADDR SHALL latch Address=byte[ADDR_WIDTH-1:0] and move to WR_DATA; byte[7:ADDR_WIDTH] is ignored.
REQ-022 A valid byte in WR_DATA SHALL drive WrEn=1 with WrData=byte and the latched Address, then return to IDLE.
REQ-023 A valid byte in RD_ADDR SHALL drive RdEn=1 with Address=byte[ADDR_WIDTH-1:0], then return to IDLE.
REQ-024 A valid byte in ALU_OPA SHALL drive WrEn=1, Address=0, WrData=byte, then move to ALU_OPB.
REQ-025 A valid byte in ALU_OPB SHALL drive WrEn=1, Address=1, WrData=byte, then move to ALU_FUN_S.
REQ-026 A valid byte in ALU_FUN_S SHALL drive ALU_EN=1 with ALU_FUN=byte[3:0], then return to IDLE.
REQ-027 All strobes SHALL be registered and asserted exactly one cycle after the accepting RX_D_VLD cycle, for exactly one cycle.
REQ-028 A byte with RX_D_VLD=1 and Parity_Error or Frame_Error=1 SHALL be discarded in every state.
REQ-029 A discarded byte SHALL pulse CMD_ERR one cycle later and force IDLE, with no strobe.
REQ-030 A byte is never taken as an opcode on the cycle it aborts a command; the next valid byte is decoded as an opcode.
REQ-031 RX_D_VLD=0 SHALL hold the state and all latched fields; there is no limit on inter-byte gap except per REQ-036.
REQ-032 WrEn, RdEn and ALU_EN SHALL be mutually exclusive on every cycle.
REQ-033 Address, WrData and ALU_FUN SHALL hold their last values when no strobe is asserted.

Reset
REQ-034 With rst=1 at a rising CLK edge, the block SHALL set state=IDLE and every output to 0 on that edge.
REQ-035 Reset asserted mid-command SHALL abandon the partial command with no strobe and no CMD_ERR.

Configuration
REQ-036 With macro UART_CMD_FRAME_TIMEOUT_EN defined:
  - a counter clears on every RX_D_VLD and increments each cycle in any non-IDLE state;
  - on reaching TIMEOUT_CYCLES, the block SHALL pulse CMD_ERR and force IDLE;
  - a timeout coinciding with RX_D_VLD SHALL yield to the byte, and the byte is processed normally.
REQ-037 Without UART_CMD_FRAME_TIMEOUT_EN, the block SHALL contain no timeout counter and a partial command SHALL wait indefinitely.

Verification
REQ-038 Bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; CMD_BUSY=0 afterwards.
REQ-039 Bytes BB,0E -> one RdEn pulse with Address=0xE; bytes BB,F7 -> RdEn with Address=0x7.
REQ-040 Bytes CC,12,34,02 -> WrEn(Addr 0, 0x12), then WrEn(Addr 1, 0x34), then ALU_EN with ALU_FUN=2; bytes DD,03 -> ALU_EN only, ALU_FUN=3.
REQ-041 Bytes AA,04 then a byte with Parity_Error=1, then 0x55 -> CMD_ERR pulse, no WrEn, 0x55 rejected as opcode with a second CMD_ERR.
REQ-042 Bytes CC,11 then rst=1 for 1 cycle, then DD,01 -> no ALU_EN for the first command; ALU_EN with ALU_FUN=1 after DD,01.
REQ-043 With UART_CMD_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - byte AA, then idle 16 cycles -> CMD_ERR pulse and CMD_BUSY=0;
  - same sequence without the macro -> CMD_BUSY stays 1.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes UART byte streams (AA wr / BB rd / CC alu-ops / DD alu-fun) into register-file and ALU strobes.
// Latency: every strobe (WrEn/RdEn/ALU_EN/CMD_ERR) is registered, one cycle after the accepting RX_D_VLD cycle.
// Backpressure: none; one byte is consumed per RX_D_VLD strobe. Optional inter-byte timeout via `UART_CMD_FRAME_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  Parity_Error,
  input  logic                  Frame_Error,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CMD_BUSY,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ADDR   = 3'd1,
    WR_DATA   = 3'd2,
    RD_ADDR   = 3'd3,
    ALU_OPA   = 3'd4,
    ALU_OPB   = 3'd5,
    ALU_FUN_S = 3'd6
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;   // address byte of a pending AA command
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic                  alu_en_q;
  logic                  cmd_err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [3:0]            alu_fun_q;
  logic                  byte_bad;
  logic                  timeout;

  assign byte_bad = Parity_Error | Frame_Error;

`ifdef UART_CMD_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q;

  // Inter-byte idle counter: runs only while a command is partially received.
  always_ff @(posedge CLK) begin
    if (rst || RX_D_VLD || (state_q == IDLE)) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state_q != IDLE) && !RX_D_VLD &&
                   (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Command FSM with registered strobes; Address/WrData/ALU_FUN only change alongside a strobe.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      if (RX_D_VLD && byte_bad) begin
        // Corrupt byte aborts whatever was in flight; it is never decoded.
        cmd_err_q <= 1'b1;
        state_q   <= IDLE;
      end else if (RX_D_VLD) begin
        unique case (state_q)
          IDLE: begin
            if (RX_P_DATA == OP_WR) begin
              state_q <= WR_ADDR;
            end else if (RX_P_DATA == OP_RD) begin
              state_q <= RD_ADDR;
            end else if (RX_P_DATA == OP_ALU) begin
              state_q <= ALU_OPA;
            end else if (RX_P_DATA == OP_FUN) begin
              state_q <= ALU_FUN_S;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
          WR_ADDR: begin
            wr_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q   <= WR_DATA;
          end
          WR_DATA: begin
            wr_en_q   <= 1'b1;
            addr_q    <= wr_addr_q;
            wr_data_q <= RX_P_DATA;
            state_q   <= IDLE;
          end
          RD_ADDR: begin
            rd_en_q <= 1'b1;
            addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q <= IDLE;
          end
          ALU_OPA: begin
            wr_en_q   <= 1'b1;
            addr_q    <= '0;
            wr_data_q <= RX_P_DATA;
            state_q   <= ALU_OPB;
          end
          ALU_OPB: begin
            wr_en_q   <= 1'b1;
            addr_q    <= ADDR_WIDTH'(1);
            wr_data_q <= RX_P_DATA;
            state_q   <= ALU_FUN_S;
          end
          ALU_FUN_S: begin
            alu_en_q  <= 1'b1;
            alu_fun_q <= RX_P_DATA[3:0];
            state_q   <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end else if (timeout) begin
        cmd_err_q <= 1'b1;
        state_q   <= IDLE;
      end
    end
  end

  assign WrEn     = wr_en_q;
  assign RdEn     = rd_en_q;
  assign ALU_EN   = alu_en_q;
  assign CMD_ERR  = cmd_err_q;
  assign Address  = addr_q;
  assign WrData   = wr_data_q;
  assign ALU_FUN  = alu_fun_q;
  assign CMD_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed command sequences with literal expectations, then random byte traffic.
// The reference model keeps the bytes of the command in flight in a queue and decides outputs from its contents.
// Outputs are compared every cycle on the falling edge; inputs change 1 time unit after the rising edge.
module tb_uart_cmd_parser;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       Parity_Error;
  logic       Frame_Error;
  logic       WrEn, RdEn, ALU_EN, CMD_BUSY, CMD_ERR;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [3:0] ALU_FUN;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  uart_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .rst(rst), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Parity_Error(Parity_Error), .Frame_Error(Frame_Error),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CMD_BUSY(CMD_BUSY), .CMD_ERR(CMD_ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] frm[$];
  int         gap;
  logic       e_wr, e_rd, e_alu, e_err;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_data;

  function automatic void decode();
    logic [7:0] b0, b1, bl;
    int n;
    n  = frm.size();
    b0 = frm[0];
    b1 = (n > 1) ? frm[1] : 8'h00;
    bl = frm[n-1];
    case (b0)
      8'hAA: if (n == 3) begin e_wr = 1; e_addr = b1[3:0]; e_data = bl; frm.delete(); end
      8'hBB: if (n == 2) begin e_rd = 1; e_addr = bl[3:0]; frm.delete(); end
      8'hCC: begin
        if (n == 4) begin e_alu = 1; e_fun = bl[3:0]; frm.delete(); end
        else if (n >= 2) begin e_wr = 1; e_addr = 4'(n - 2); e_data = bl; end
      end
      8'hDD: if (n == 2) begin e_alu = 1; e_fun = bl[3:0]; frm.delete(); end
      default: begin e_err = 1; frm.delete(); end
    endcase
  endfunction

  always @(posedge CLK) begin
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (rst) begin
      frm.delete(); gap = 0; e_addr = 0; e_data = 0; e_fun = 0;
    end else if (RX_D_VLD) begin
      gap = 0;
      if (Parity_Error || Frame_Error) begin
        e_err = 1; frm.delete();
      end else begin
        frm.push_back(RX_P_DATA);
        decode();
      end
    end else if (frm.size() != 0) begin
`ifdef UART_CMD_FRAME_TIMEOUT_EN
      gap++;
      if (gap == TO) begin e_err = 1; frm.delete(); gap = 0; end
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("WrEn", WrEn, e_wr);
      chk("RdEn", RdEn, e_rd);
      chk("ALU_EN", ALU_EN, e_alu);
      chk("CMD_ERR", CMD_ERR, e_err);
      chk("CMD_BUSY", CMD_BUSY, frm.size() != 0);
      chk("Address", Address, e_addr);
      chk("WrData", WrData, e_data);
      chk("ALU_FUN", ALU_FUN, e_fun);
      chk("strobe_excl", 32'(WrEn) + 32'(RdEn) + 32'(ALU_EN) <= 1, 1);
    end
  end

  // ---------------- stimulus ----------------
  // Drive one byte for one cycle; returns 1 unit after the sampling edge so its strobe is visible.
  task automatic put(input logic [7:0] d, input logic pe = 0, input logic fe = 0);
    @(posedge CLK); #1;
    RX_P_DATA = d; RX_D_VLD = 1; Parity_Error = pe; Frame_Error = fe;
    @(posedge CLK); #1;
    RX_D_VLD = 0; Parity_Error = 0; Frame_Error = 0; RX_P_DATA = $urandom_range(0, 255);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  logic [7:0] ops[4];

  initial begin
    ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
    rst = 1; RX_D_VLD = 0; RX_P_DATA = 0; Parity_Error = 0; Frame_Error = 0;
    repeat (2) @(posedge CLK);
    #1; rst = 0; chk_en = 1;
    chk("rst_busy", CMD_BUSY, 0);
    chk("rst_wren", WrEn, 0);
    chk("rst_addr", Address, 0);
    chk("rst_err", CMD_ERR, 0);

    // AA,05,3C -> single write
    put(8'hAA); put(8'h05); put(8'h3C);
    chk("wr_en", WrEn, 1); chk("wr_addr", Address, 5); chk("wr_data", WrData, 8'h3C);
    chk("model_wr_addr", e_addr, 5);
    idle(1);
    chk("wr_done_en", WrEn, 0); chk("wr_done_busy", CMD_BUSY, 0); chk("wr_hold_addr", Address, 5);

    // BB,0E and BB,F7 (upper nibble ignored)
    put(8'hBB); put(8'h0E);
    chk("rd_en", RdEn, 1); chk("rd_addr", Address, 4'hE);
    put(8'hBB); put(8'hF7);
    chk("rd_en2", RdEn, 1); chk("rd_addr2", Address, 4'h7);

    // CC,12,34,02 then DD,03
    put(8'hCC); put(8'h12);
    chk("opa_en", WrEn, 1); chk("opa_addr", Address, 0); chk("opa_data", WrData, 8'h12);
    put(8'h34);
    chk("opb_en", WrEn, 1); chk("opb_addr", Address, 1); chk("opb_data", WrData, 8'h34);
    put(8'h02);
    chk("alu_en", ALU_EN, 1); chk("alu_fun", ALU_FUN, 2); chk("alu_nowr", WrEn, 0);
    chk("model_alu_fun", e_fun, 2);
    put(8'hDD); put(8'h03);
    chk("fun_en", ALU_EN, 1); chk("fun_val", ALU_FUN, 3);

    // AA,04, parity-bad byte, then 0x55 rejected as opcode
    put(8'hAA); put(8'h04); put(8'h9A, 1, 0);
    chk("perr_err", CMD_ERR, 1); chk("perr_nowr", WrEn, 0); chk("perr_busy", CMD_BUSY, 0);
    put(8'h55);
    chk("bad_op_err", CMD_ERR, 1); chk("bad_op_busy", CMD_BUSY, 0);

    // Frame error mid read
    put(8'hBB); put(8'h03, 0, 1);
    chk("ferr_err", CMD_ERR, 1); chk("ferr_nord", RdEn, 0);

    // CC,11 then reset abandons the command silently, DD,01 works afterwards
    put(8'hCC); put(8'h11);
    @(posedge CLK); #1; rst = 1;
    @(posedge CLK); #1; rst = 0;
    chk("rst_mid_busy", CMD_BUSY, 0); chk("rst_mid_err", CMD_ERR, 0); chk("rst_mid_alu", ALU_EN, 0);
    put(8'hDD); put(8'h01);
    chk("after_rst_alu", ALU_EN, 1); chk("after_rst_fun", ALU_FUN, 1);

    // AA then 16 idle cycles
    put(8'hAA);
    idle(TO);
`ifdef UART_CMD_FRAME_TIMEOUT_EN
    chk("to_err", CMD_ERR, 1); chk("to_busy", CMD_BUSY, 0);
`else
    chk("no_to_err", CMD_ERR, 0); chk("no_to_busy", CMD_BUSY, 1);
    idle(40);
    chk("no_to_busy_long", CMD_BUSY, 1);
`endif
    @(posedge CLK); #1; rst = 1;
    @(posedge CLK); #1; rst = 0;

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK); #1;
      rst          = ($urandom_range(0, 299) == 0);
      RX_D_VLD     = ($urandom_range(0, 2) != 0);
      RX_P_DATA    = ($urandom_range(0, 9) < 4) ? ops[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
      Parity_Error = ($urandom_range(0, 19) == 0);
      Frame_Error  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        RX_D_VLD = 0;
        repeat ($urandom_range(5, 20)) @(posedge CLK);
        #1;
      end
    end
    @(posedge CLK); #1;
    RX_D_VLD = 0; rst = 0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
